video_scanlines: RTL and testbench

VIDEO_SCANLINES -- requirements
Module: video_scanlines

---
 rtl/video_scanlines.sv | 193 +++++++++++++++++++
 tb/tb_video_scanlines.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/video_scanlines.sv
// Scanline dimming stage for a cleaned video stream.
// Two-stage pixel pipeline: stage 1 samples the stream and decides the dim
// level, stage 2 applies the dim arithmetic and blanks colour outside DE.
// In parallel, the active area is measured each frame and published on VS.
module video_scanlines #(
    parameter int DATA_W = 8
) (
    input  logic              clk_vid,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [1:0]        scanlines,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] G,
    input  logic [DATA_W-1:0] B,
    input  logic              HS,
    input  logic              VS,
    input  logic              DE,
    output logic [DATA_W-1:0] VGA_R,
    output logic [DATA_W-1:0] VGA_G,
    output logic [DATA_W-1:0] VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_DE,
    output logic [11:0]       hact,
    output logic [11:0]       vact,
    output logic              frame_valid
);

    localparam int CNT_W = 12;

    // Dim arithmetic; mode 0 passes the channel through untouched.
    function automatic logic [DATA_W-1:0] dim_chan(input logic [DATA_W-1:0] c,
                                                   input logic [1:0]        mode);
        logic [DATA_W-1:0] res;
        case (mode)
            2'd1:    res = (c >> 1) + (c >> 2);
            2'd2:    res = c >> 1;
            2'd3:    res = c >> 2;
            default: res = c;
        endcase
        return res;
    endfunction

    // Saturating increment for the 12-bit measurement counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- stage 1 registers (also serve as previous-sample history) ----
    logic [DATA_W-1:0] r_p1_q, g_p1_q, b_p1_q;
    logic              hs_p1_q, vs_p1_q, de_p1_q;
    logic [1:0]        mode_p1_q;

    // ---- stage 2 registers (drive the outputs) ----
    logic [DATA_W-1:0] r_p2_q, g_p2_q, b_p2_q;
    logic              hs_p2_q, vs_p2_q, de_p2_q;

    // ---- frame / line state ----
    logic [1:0]        lvl_q, lvl_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  hline_q, hline_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic [CNT_W-1:0]  hact_q, hact_d;
    logic [CNT_W-1:0]  vact_q, vact_d;
    logic              fv_q, fv_d;

    logic              vs_rise, de_rise, de_fall;
    logic [CNT_W-1:0]  hline_cap, vact_cap;
    logic [1:0]        mode_d;

    // Edges compare the current sample against the one held in stage 1.
    assign vs_rise = VS & ~vs_p1_q;
    assign de_rise = DE & ~de_p1_q;
    assign de_fall = ~DE & de_p1_q;

    // A line completing on the VS sample itself still belongs to the frame.
    assign hline_cap = de_fall ? hcnt_q : hline_q;
    assign vact_cap  = de_fall ? sat_inc(vcnt_q) : vcnt_q;

    // Odd lines of a frame with a non-zero level carry the level into stage 2.
    assign mode_d = (par_q && (lvl_q != 2'd0)) ? lvl_q : 2'd0;

    // Next-state logic for level, parity and the active-area measurement.
    always_comb begin
        lvl_d   = lvl_q;
        par_d   = par_q;
        hcnt_d  = hcnt_q;
        hline_d = hline_q;
        vcnt_d  = vcnt_q;
        hact_d  = hact_q;
        vact_d  = vact_q;
        fv_d    = fv_q;
        if (ce_pix) begin
            // The rising sample is itself an active pixel, so restart at 1.
            if (de_rise) begin
                hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (DE) begin
                hcnt_d = sat_inc(hcnt_q);
            end
            if (de_fall) begin
                hline_d = hcnt_q;
                vcnt_d  = sat_inc(vcnt_q);
                par_d   = ~par_q;
            end
            // VS wins over the DE-fall toggle and restarts the line count.
            if (vs_rise) begin
                lvl_d  = scanlines;
                par_d  = 1'b0;
                vcnt_d = '0;
                if (vact_cap != '0) begin
                    hact_d = hline_cap;
                    vact_d = vact_cap;
                    fv_d   = 1'b1;
                end
            end
        end
    end

    // Frame / line state registers.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            lvl_q   <= '0;
            par_q   <= 1'b0;
            hcnt_q  <= '0;
            hline_q <= '0;
            vcnt_q  <= '0;
            hact_q  <= '0;
            vact_q  <= '0;
            fv_q    <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            par_q   <= par_d;
            hcnt_q  <= hcnt_d;
            hline_q <= hline_d;
            vcnt_q  <= vcnt_d;
            hact_q  <= hact_d;
            vact_q  <= vact_d;
            fv_q    <= fv_d;
        end
    end

    // Stage 1: sample the stream and latch the dim decision.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_p1_q    <= '0;
            g_p1_q    <= '0;
            b_p1_q    <= '0;
            hs_p1_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
            de_p1_q   <= 1'b0;
            mode_p1_q <= '0;
        end else if (ce_pix) begin
            r_p1_q    <= R;
            g_p1_q    <= G;
            b_p1_q    <= B;
            hs_p1_q   <= HS;
            vs_p1_q   <= VS;
            de_p1_q   <= DE;
            mode_p1_q <= mode_d;
        end
    end

    // Stage 2: apply dimming, blank colour outside DE, drive outputs.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_p2_q  <= '0;
            g_p2_q  <= '0;
            b_p2_q  <= '0;
            hs_p2_q <= 1'b0;
            vs_p2_q <= 1'b0;
            de_p2_q <= 1'b0;
        end else if (ce_pix) begin
            r_p2_q  <= de_p1_q ? dim_chan(r_p1_q, mode_p1_q) : '0;
            g_p2_q  <= de_p1_q ? dim_chan(g_p1_q, mode_p1_q) : '0;
            b_p2_q  <= de_p1_q ? dim_chan(b_p1_q, mode_p1_q) : '0;
            hs_p2_q <= hs_p1_q;
            vs_p2_q <= vs_p1_q;
            de_p2_q <= de_p1_q;
        end
    end

    assign VGA_R       = r_p2_q;
    assign VGA_G       = g_p2_q;
    assign VGA_B       = b_p2_q;
    assign VGA_HS      = hs_p2_q;
    assign VGA_VS      = vs_p2_q;
    assign VGA_DE      = de_p2_q;
    assign hact        = hact_q;
    assign vact        = vact_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_video_scanlines.sv
// Directed bench for video_scanlines: latency, dim levels, frame measurement,
// sparse pixel enables and mid-frame reset.
module tb_video_scanlines;

    logic       clk_vid = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [1:0] scanlines;
    logic [7:0] R, G, B;
    logic       HS, VS, DE;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_DE;
    logic [11:0] hact, vact;
    logic       frame_valid;

    int n_chk = 0;
    int n_err = 0;
    int div   = 1;
    logic [7:0] cr, cg, cb;

    // Hand-computed results for R=FF, G=81, B=03 at levels 0..3.
    logic [23:0] tab [4] = '{24'hFF8103, 24'hBE6001, 24'h7F4001, 24'h3F2000};

    video_scanlines dut (
        .clk_vid     (clk_vid),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .scanlines   (scanlines),
        .R           (R),
        .G           (G),
        .B           (B),
        .HS          (HS),
        .VS          (VS),
        .DE          (DE),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_DE      (VGA_DE),
        .hact        (hact),
        .vact        (vact),
        .frame_valid (frame_valid)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel sample; with div>1 the enable is low for div-1 idle cycles.
    task automatic smp(input logic de, input logic hs, input logic vs);
        logic [26:0] snap;
        DE = de; HS = hs; VS = vs;
        R = cr; G = cg; B = cb;
        ce_pix = 1'b1;
        @(posedge clk_vid); #1;
        if (div > 1) begin
            snap = {VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B};
            ce_pix = 1'b0;
            repeat (div - 1) @(posedge clk_vid);
            #1;
            chk("hold_idle", {5'd0, VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B}, {5'd0, snap});
        end
    endtask

    task automatic vs_pulse();
        smp(1'b0, 1'b0, 1'b1);
        smp(1'b0, 1'b0, 1'b1);
        smp(1'b0, 1'b0, 1'b0);
        smp(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [23:0] exp_col(input int lvl, input int odd);
        return (odd != 0 && lvl != 0) ? tab[lvl] : tab[0];
    endfunction

    // n lines of w pixels; blanking of 2 samples except hb_last after the last.
    task automatic lines(input int n, input int w, input int hb_last,
                         input int lvl, input bit chkit);
        for (int l = 0; l < n; l++) begin
            for (int k = 0; k < w; k++) begin
                smp(1'b1, 1'b0, 1'b0);
                if (chkit && k == 2)
                    chk($sformatf("pix_l%0d_lvl%0d", l, lvl),
                        {7'd0, VGA_DE, VGA_R, VGA_G, VGA_B}, {7'd0, 1'b1, exp_col(lvl, l & 1)});
            end
            for (int k = 0; k < ((l == n - 1) ? hb_last : 2); k++)
                smp(1'b0, 1'b1, 1'b0);
        end
    endtask

    // Single pixel with HS/VS high; it must show up after the second sample.
    task automatic latency_test(input string tag);
        scanlines = 2'd0;
        cr = 8'h80; cg = 8'h00; cb = 8'h00;
        smp(1'b1, 1'b1, 1'b1);
        chk({tag, "_de_early"}, {31'd0, VGA_DE}, 32'd0);
        cr = 8'h00;
        smp(1'b0, 1'b0, 1'b0);
        chk({tag, "_out"}, {21'd0, VGA_HS, VGA_VS, VGA_DE, VGA_R}, {21'd0, 3'b111, 8'h80});
        smp(1'b0, 1'b0, 1'b0);
        chk({tag, "_after"}, {21'd0, VGA_HS, VGA_VS, VGA_DE, VGA_R}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b1; scanlines = 2'd0;
        R = 8'h55; G = 8'h55; B = 8'h55; HS = 1'b0; VS = 1'b0; DE = 1'b0;
        cr = 8'h00; cg = 8'h00; cb = 8'h00;
        repeat (3) @(posedge clk_vid);
        #1;
        chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_DE}, 32'd0);
        chk("rst_meas", {7'd0, frame_valid, hact, vact}, 32'd0);
        reset = 1'b0;

        latency_test("lat1");

        // Level tables: level latched on VS, odd lines dimmed.
        cr = 8'hFF; cg = 8'h81; cb = 8'h03;
        scanlines = 2'd2; vs_pulse(); scanlines = 2'd0; lines(4, 8, 2, 2, 1'b1);
        scanlines = 2'd1; vs_pulse(); scanlines = 2'd0; lines(4, 8, 2, 1, 1'b1);
        scanlines = 2'd3; vs_pulse(); scanlines = 2'd0; lines(4, 8, 2, 3, 1'b1);

        // Mid-frame change only takes effect after the next VS.
        scanlines = 2'd0; vs_pulse();
        lines(2, 8, 2, 0, 1'b1);
        scanlines = 2'd3;
        lines(2, 8, 2, 0, 1'b1);
        vs_pulse();
        lines(4, 8, 2, 3, 1'b1);

        // Full 320x240 frame measurement, then hold through the next frame.
        scanlines = 2'd0; vs_pulse();
        lines(240, 320, 2, 0, 1'b0);
        vs_pulse();
        chk("big_hact", {20'd0, hact}, 32'd320);
        chk("big_vact", {20'd0, vact}, 32'd240);
        chk("big_fv", {31'd0, frame_valid}, 32'd1);
        lines(3, 10, 2, 0, 1'b0);
        chk("hold_meas", {7'd0, frame_valid, hact, vact}, {7'd0, 1'b1, 12'd320, 12'd240});

        // Pixel enable every 4th cycle.
        div = 4;
        vs_pulse();
        chk("ce4_prev", {7'd0, frame_valid, hact, vact}, {7'd0, 1'b1, 12'd10, 12'd3});
        scanlines = 2'd2;
        lines(8, 12, 2, 0, 1'b1);
        vs_pulse();
        chk("ce4_meas", {7'd0, frame_valid, hact, vact}, {7'd0, 1'b1, 12'd12, 12'd8});
        lines(4, 6, 2, 2, 1'b1);
        latency_test("lat4");
        div = 1;

        // Reset in the middle of a line, with the enable low.
        cr = 8'hFF; cg = 8'h81; cb = 8'h03;
        scanlines = 2'd0; vs_pulse();
        lines(2, 8, 2, 0, 1'b0);
        smp(1'b1, 1'b0, 1'b0); smp(1'b1, 1'b0, 1'b0); smp(1'b1, 1'b0, 1'b0);
        reset = 1'b1; ce_pix = 1'b0; DE = 1'b1;
        @(posedge clk_vid); #1;
        chk("mrst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("mrst_sync", {29'd0, VGA_HS, VGA_VS, VGA_DE}, 32'd0);
        chk("mrst_meas", {7'd0, frame_valid, hact, vact}, 32'd0);
        reset = 1'b0;
        smp(1'b0, 1'b0, 1'b0);
        vs_pulse();
        chk("mrst_nocap", {7'd0, frame_valid, hact, vact}, 32'd0);
        lines(4, 6, 0, 0, 1'b0);
        vs_pulse();
        chk("mrst_cap", {7'd0, frame_valid, hact, vact}, {7'd0, 1'b1, 12'd6, 12'd4});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
